// File: rtl/detect_pkg.sv
// detect_pkg: shared types and default thresholds for the detect sequencer
package detect_pkg;
  typedef enum logic [1:0] {OTHER = 2'd0, WHITE = 2'd1, BLACK = 2'd2} frame_class_t;
  typedef enum logic [1:0] {IDLE, CONFIRM, LAUNCH, RUN} seq_state_t;
  localparam logic [7:0] BRIGHT_TH_DEF = 8'hAF;
  localparam logic [7:0] DARK_TH_DEF = 8'h1F;
  localparam int CNT_W_DEF = 20;
  localparam logic [19:0] MIN_PIX_DEF = 20'd150000;
  localparam logic [3:0] CONFIRM_DEF = 4'd3;
  localparam logic [7:0] TIMEOUT_DEF = 8'd30;
endpackage

// File: rtl/detect_sequencer_classifier.sv
// frame_classifier: counts bright/dark pixels per frame and registers the frame class
module frame_classifier
  import detect_pkg::*;
#(
  parameter logic [7:0] BRIGHT_TH = BRIGHT_TH_DEF,
  parameter logic [7:0] DARK_TH = DARK_TH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter logic [CNT_W-1:0] MIN_PIX = MIN_PIX_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pix_valid,
  input  logic         frame_end,
  input  logic [7:0]   vga_r,
  input  logic [7:0]   vga_g,
  input  logic [7:0]   vga_b,
  output frame_class_t frame_class,
  output logic         frame_class_valid
);
  logic w_bright;
  logic w_dark;
  logic [CNT_W-1:0] r_bright_cnt;
  logic [CNT_W-1:0] r_dark_cnt;
  logic [CNT_W-1:0] w_bright_nxt;
  logic [CNT_W-1:0] w_dark_nxt;
  always_comb begin
    w_bright = pix_valid && vga_r > BRIGHT_TH && vga_g > BRIGHT_TH && vga_b > BRIGHT_TH;
    w_dark = pix_valid && vga_r < DARK_TH && vga_g < DARK_TH && vga_b < DARK_TH;
    w_bright_nxt = (w_bright && !(&r_bright_cnt)) ? r_bright_cnt + 1'b1 : r_bright_cnt;
    w_dark_nxt = (w_dark && !(&r_dark_cnt)) ? r_dark_cnt + 1'b1 : r_dark_cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bright_cnt <= '0;
      r_dark_cnt <= '0;
      frame_class <= OTHER;
      frame_class_valid <= 1'b0;
    end else begin
      r_bright_cnt <= frame_end ? '0 : w_bright_nxt;
      r_dark_cnt <= frame_end ? '0 : w_dark_nxt;
      frame_class_valid <= frame_end;
      if (frame_end) begin
        if (w_bright_nxt >= MIN_PIX) frame_class <= WHITE;
        else if (w_dark_nxt >= MIN_PIX) frame_class <= BLACK;
        else frame_class <= OTHER;
      end
    end
  end
endmodule

// File: rtl/detect_sequencer.sv
// detect_sequencer: confirms white frames, launches the detection engine and supervises the run
module detect_sequencer
  import detect_pkg::*;
#(
  parameter logic [7:0] BRIGHT_TH = BRIGHT_TH_DEF,
  parameter logic [7:0] DARK_TH = DARK_TH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter logic [CNT_W-1:0] MIN_PIX = MIN_PIX_DEF,
  parameter logic [3:0] CONFIRM_FRAMES = CONFIRM_DEF,
  parameter logic [7:0] TIMEOUT_FRAMES = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_valid,
  input  logic       frame_end,
  input  logic [7:0] vga_r,
  input  logic [7:0] vga_g,
  input  logic [7:0] vga_b,
  input  logic       det_ready,
  input  logic       det_done,
  output logic       start_detect,
  output logic       finish_detect,
  output logic       detecting,
  output logic       abort_detect,
  output logic       timeout,
  output logic [1:0] frame_class,
  output logic       frame_class_valid
);
  frame_class_t w_class;
  logic w_valid;
  seq_state_t r_state;
  logic [3:0] r_conf_cnt;
  logic [7:0] r_frame_cnt;
  frame_classifier #(
    .BRIGHT_TH(BRIGHT_TH),
    .DARK_TH(DARK_TH),
    .CNT_W(CNT_W),
    .MIN_PIX(MIN_PIX)
  ) u_cls (
    .clk(clk),
    .rst(rst),
    .pix_valid(pix_valid),
    .frame_end(frame_end),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .frame_class(w_class),
    .frame_class_valid(w_valid)
  );
  assign frame_class = w_class;
  assign frame_class_valid = w_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_conf_cnt <= '0;
      r_frame_cnt <= '0;
      start_detect <= 1'b0;
      finish_detect <= 1'b1;
      detecting <= 1'b0;
      abort_detect <= 1'b0;
      timeout <= 1'b0;
    end else begin
      abort_detect <= 1'b0;
      timeout <= 1'b0;
      case (r_state)
        IDLE: if (w_valid && w_class == WHITE) begin
          r_conf_cnt <= 4'd1;
          if (CONFIRM_FRAMES == 4'd1) begin
            r_state <= LAUNCH;
            start_detect <= 1'b1;
            finish_detect <= 1'b0;
          end else r_state <= CONFIRM;
        end
        CONFIRM: if (w_valid) begin
          if (w_class == WHITE) begin
            r_conf_cnt <= r_conf_cnt + 4'd1;
            if (r_conf_cnt + 4'd1 == CONFIRM_FRAMES) begin
              r_state <= LAUNCH;
              start_detect <= 1'b1;
              finish_detect <= 1'b0;
            end
          end else begin
            r_conf_cnt <= '0;
            r_state <= IDLE;
          end
        end
        LAUNCH: if (det_ready) begin
          r_state <= RUN;
          start_detect <= 1'b0;
          detecting <= 1'b1;
          r_frame_cnt <= '0;
          r_conf_cnt <= '0;
        end
        RUN: if (det_done || (w_valid && (w_class == BLACK || r_frame_cnt + 8'd1 == TIMEOUT_FRAMES))) begin
          r_state <= IDLE;
          detecting <= 1'b0;
          finish_detect <= 1'b1;
          abort_detect <= !det_done && w_class == BLACK;
          timeout <= !det_done && w_class != BLACK;
        end else if (w_valid) r_frame_cnt <= r_frame_cnt + 8'd1;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_detect_sequencer.sv
// tb_detect_sequencer: directed self-checking bench for detect_sequencer
module tb_detect_sequencer;
  import detect_pkg::*;
  logic clk;
  logic rst;
  logic pix_valid;
  logic frame_end;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;
  logic det_ready;
  logic det_done;
  logic start_detect;
  logic finish_detect;
  logic detecting;
  logic abort_detect;
  logic timeout;
  logic [1:0] frame_class;
  logic frame_class_valid;
  int n_cmp = 0;
  int n_fail = 0;
  detect_sequencer #(
    .CNT_W(8),
    .MIN_PIX(8'd150)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pix_valid(pix_valid),
    .frame_end(frame_end),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .det_ready(det_ready),
    .det_done(det_done),
    .start_detect(start_detect),
    .finish_detect(finish_detect),
    .detecting(detecting),
    .abort_detect(abort_detect),
    .timeout(timeout),
    .frame_class(frame_class),
    .frame_class_valid(frame_class_valid)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic pixels(input int n, input logic [7:0] v, input bit fe);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      vga_r = v;
      vga_g = v;
      vga_b = v;
      frame_end = fe && (i == n - 1);
      tick();
    end
    pix_valid = 1'b0;
    frame_end = 1'b0;
  endtask
  task automatic launch_run();
    det_ready = 1'b1;
    for (int i = 0; i < 3; i++) pixels(200, 8'hFF, 1'b1);
    tick();
    tick();
  endtask
  initial begin
    rst = 1'b1;
    pix_valid = 1'b0;
    frame_end = 1'b0;
    vga_r = 8'h00;
    vga_g = 8'h00;
    vga_b = 8'h00;
    det_ready = 1'b1;
    det_done = 1'b0;
    tick();
    tick();
    chk("rst_start", start_detect, 0);
    chk("rst_finish", finish_detect, 1);
    chk("rst_detecting", detecting, 0);
    chk("rst_abort", abort_detect, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_class", frame_class, OTHER);
    chk("rst_class_valid", frame_class_valid, 0);
    rst = 1'b0;
    tick();
    pixels(200, 8'hFF, 1'b1);
    chk("t1_class1", frame_class, WHITE);
    chk("t1_valid1", frame_class_valid, 1);
    tick();
    chk("t1_valid_pulse", frame_class_valid, 0);
    chk("t1_state_confirm", dut.r_state, CONFIRM);
    pixels(200, 8'hFF, 1'b1);
    chk("t1_class2", frame_class, WHITE);
    pixels(200, 8'hFF, 1'b1);
    chk("t1_class3", frame_class, WHITE);
    chk("t1_start_early", start_detect, 0);
    tick();
    chk("t1_start", start_detect, 1);
    chk("t1_finish_low", finish_detect, 0);
    tick();
    chk("t1_start_drop", start_detect, 0);
    chk("t1_detecting", detecting, 1);
    det_done = 1'b1;
    tick();
    det_done = 1'b0;
    chk("t1_done_idle", detecting, 0);
    chk("t1_done_finish", finish_detect, 1);
    chk("t1_done_no_abort", abort_detect, 0);
    pixels(200, 8'hFF, 1'b1);
    pixels(200, 8'hFF, 1'b1);
    pixels(200, 8'h80, 1'b1);
    chk("t2_class_other", frame_class, OTHER);
    pixels(200, 8'hFF, 1'b1);
    tick();
    chk("t2_state", dut.r_state, CONFIRM);
    chk("t2_conf_cnt", dut.r_conf_cnt, 1);
    chk("t2_no_start", start_detect, 0);
    pixels(1, 8'h80, 1'b1);
    tick();
    chk("t2_back_idle", dut.r_state, IDLE);
    det_ready = 1'b0;
    for (int i = 0; i < 3; i++) pixels(200, 8'hFF, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t3_start_held", start_detect, 1);
    end
    det_ready = 1'b1;
    tick();
    chk("t3_start_drop", start_detect, 0);
    chk("t3_run", detecting, 1);
    pixels(160, 8'h00, 1'b1);
    chk("t4_class_black", frame_class, BLACK);
    chk("t4_abort_early", abort_detect, 0);
    tick();
    chk("t4_abort", abort_detect, 1);
    chk("t4_finish", finish_detect, 1);
    chk("t4_detecting", detecting, 0);
    tick();
    chk("t4_abort_pulse", abort_detect, 0);
    launch_run();
    chk("t5_run", detecting, 1);
    for (int i = 0; i < 30; i++) begin
      pixels(1, 8'h80, 1'b1);
      chk("t5_still_run", detecting, 1);
      chk("t5_no_timeout", timeout, 0);
    end
    tick();
    chk("t5_timeout", timeout, 1);
    chk("t5_timeout_idle", detecting, 0);
    chk("t5_timeout_finish", finish_detect, 1);
    tick();
    chk("t5_timeout_pulse", timeout, 0);
    launch_run();
    for (int i = 0; i < 30; i++) pixels(1, 8'h80, 1'b1);
    det_done = 1'b1;
    tick();
    det_done = 1'b0;
    chk("t5b_no_timeout", timeout, 0);
    chk("t5b_idle", detecting, 0);
    chk("t5b_finish", finish_detect, 1);
    tick();
    chk("t5b_no_timeout2", timeout, 0);
    pixels(200, 8'hAF, 1'b1);
    chk("bnd_bright_th", frame_class, OTHER);
    pixels(200, 8'h1F, 1'b1);
    chk("bnd_dark_th", frame_class, OTHER);
    pixels(149, 8'h00, 1'b1);
    chk("bnd_min_minus1", frame_class, OTHER);
    pixels(150, 8'h00, 1'b1);
    chk("bnd_min_black", frame_class, BLACK);
    tick();
    chk("bnd_black_idle_no_abort", abort_detect, 0);
    pixels(200, 8'hB0, 1'b1);
    chk("bnd_b0_white", frame_class, WHITE);
    pixels(1, 8'h80, 1'b1);
    tick();
    chk("bnd_back_idle", dut.r_state, IDLE);
    pixels(265, 8'hFF, 1'b0);
    chk("t6_saturated", dut.u_cls.r_bright_cnt, 8'hFF);
    pixels(1, 8'hFF, 1'b1);
    chk("t6_sat_white", frame_class, WHITE);
    chk("t6_cnt_clear", dut.u_cls.r_bright_cnt, 0);
    pixels(200, 8'hFF, 1'b1);
    pixels(200, 8'hFF, 1'b1);
    tick();
    tick();
    chk("t6_run", detecting, 1);
    rst = 1'b1;
    tick();
    chk("t6_rst_finish", finish_detect, 1);
    chk("t6_rst_detecting", detecting, 0);
    chk("t6_rst_abort", abort_detect, 0);
    chk("t6_rst_state", dut.r_state, IDLE);
    rst = 1'b0;
    tick();
    chk("t6_rst_no_abort", abort_detect, 0);
    chk("t6_rst_no_timeout", timeout, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/detect_sequencer.md
Name: detect_sequencer

Overview:
- Sequences the detection engine from the live VGA pixel stream.
- Classifies each frame as WHITE, BLACK or OTHER by counting bright and dark pixels.
- Requires CONFIRM_FRAMES consecutive WHITE frames, then launches the engine with a valid/ready handshake.
- Supervises the run until the engine reports done, a BLACK frame aborts it, or a frame-count timeout expires.

Parameters:
BRIGHT_TH, 8'hAF, a pixel is bright when r, g and b are all strictly greater than this.
DARK_TH, 8'h1F, a pixel is dark when r, g and b are all strictly less than this.
MIN_PIX, 20'd150000, minimum bright (or dark) pixel count for a frame to be WHITE (or BLACK).
CNT_W, 20, width of the per-frame pixel counters.
CONFIRM_FRAMES, 3, consecutive WHITE frames needed to launch; legal range 1..15.
TIMEOUT_FRAMES, 30, maximum frames allowed in RUN; legal range 1..255.

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
pix_valid  in  1  vga_r/g/b carry a visible pixel this cycle
frame_end  in  1  one-cycle strobe marking the end of a frame
vga_r  in  8  red
vga_g  in  8  green
vga_b  in  8  blue
det_ready  in  1  engine accepts a start
det_done  in  1  one-cycle pulse: engine finished
start_detect  out  1  start request; held until accepted
finish_detect  out  1  high when idle (no detection in progress)
detecting  out  1  high in RUN
abort_detect  out  1  one-cycle pulse: run cancelled by a BLACK frame
timeout  out  1  one-cycle pulse: run exceeded TIMEOUT_FRAMES
frame_class  out  2  last frame classification: 0=OTHER, 1=WHITE, 2=BLACK
frame_class_valid  out  1  one-cycle pulse when frame_class updates

Behaviour:
Reset values:
- start_detect=0, finish_detect=1, detecting=0, abort_detect=0, timeout=0.
- frame_class=OTHER, frame_class_valid=0.
- State=IDLE; all counters 0. Reset mid-run drops start_detect immediately and returns to IDLE; no abort or timeout pulse is issued.

Classifier:
- bright_cnt and dark_cnt increment on pix_valid pixels that meet the threshold. They saturate at all-ones and never wrap.
- If pix_valid and frame_end coincide, that pixel counts toward the ending frame.
- On frame_end: WHITE if bright_cnt>=MIN_PIX; else BLACK if dark_cnt>=MIN_PIX; else OTHER. WHITE wins when both thresholds are met.
- The result is registered: frame_class and frame_class_valid update 1 cycle after frame_end.
- Counters clear on the frame_end cycle; the first pixel of the next frame counts from 0 in the following cycle.
- The FSM acts on the registered class, i.e. while frame_class_valid=1.

FSM:
- IDLE (finish_detect=1)
  - On a WHITE class: conf_cnt=1 and go to CONFIRM; if CONFIRM_FRAMES==1, go directly to LAUNCH.
- CONFIRM (finish_detect=1)
  - WHITE: conf_cnt++; when conf_cnt reaches CONFIRM_FRAMES, go to LAUNCH.
  - OTHER or BLACK: conf_cnt=0, go to IDLE.
- LAUNCH
  - start_detect=1, finish_detect=0. Hold until det_ready=1; the handshake completes that cycle.
  - Next state is RUN with frame_cnt=0.
  - Frame classes are ignored while in LAUNCH.
- RUN (detecting=1, finish_detect=0)
  - det_done: go to IDLE.
  - BLACK class: abort_detect pulse, go to IDLE.
  - Any other class: frame_cnt++; when it reaches TIMEOUT_FRAMES, timeout pulse and go to IDLE.
  - If det_done and a class arrive in the same cycle, det_done wins: no abort or timeout pulse.
- finish_detect rises in the cycle after the exit from RUN.
- A new confirmation sequence can start only from frames classified after the return to IDLE.

Decomposition:
Package detect_pkg:
- frame_class_t enum (OTHER, WHITE, BLACK).
- seq_state_t enum (IDLE, CONFIRM, LAUNCH, RUN).
- Default threshold constants.
Sub-module frame_classifier:
- Contains the threshold compare, the saturating counters and the registered class output.
- detect_sequencer instantiates it and contains the FSM plus conf_cnt and frame_cnt.

Test Plan:
1. Reset, then 3 frames of 200000 pixels at 0xFF, det_ready=1: frame_class=WHITE after each frame_end. start_detect is high for exactly 1 cycle at 1 cycle after the 3rd classification. detecting=1 the next cycle.
2. Pattern WHITE, WHITE, OTHER (pixels 0x80), WHITE: no start_detect; state is CONFIRM with conf_cnt=1 after the last frame.
3. Launch with det_ready held 0 for 5 cycles: start_detect stays high for 6 cycles. It drops the cycle after det_ready=1; RUN is entered.
4. In RUN, one frame of 160000 pixels at 0x00: frame_class=BLACK, abort_detect 1-cycle pulse; finish_detect=1 the next cycle.
5. In RUN, 30 OTHER frames with no det_done: timeout pulse at the 30th classification, then IDLE. Repeat with det_done in the same cycle as the 30th class: no timeout pulse.
6. Saturation and reset: 2^20+10 bright pixels in one frame give WHITE with the counter at 0xFFFFF. Asserting rst in RUN gives finish_detect=1 and detecting=0 the next cycle, with no abort pulse.
